io_mem_ctrl: RTL and testbench
==============================

Name: io_mem_ctrl

Overview:
- Parametrised, clocked memory-mapped I/O block on the processor's load/store path.
- Exposes individually addressable bits: writable GPIO outputs, synchronised GPIO inputs and debounced switches.
- Adds sticky rising-edge flags per switch with write-1-to-clear, and a pending-event output.
- Read data is registered and accompanied by a valid strobe.

Parameters:
- DATA_W, 24, width of data_in / data_out.
- ADDR_W, 8, address width.
- N_OUT, 36, number of writable output bits.
- N_IN, 36, number of GPIO input bits.
- N_SW, 4, number of switches.
- SYNC_STAGES, 2, synchroniser flops per input bit (>=2).
- DEBOUNCE, 16, consecutive stable cycles required to accept a switch change (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable, sampled on clk
- re  in  1  read enable, sampled on clk
- address  in  ADDR_W  bit address
- data_in  in  DATA_W  write data; only bit 0 used
- switches  in  N_SW  raw asynchronous switch inputs
- gpio_in  in  N_IN  raw asynchronous GPIO inputs
- gpio_out  out  N_OUT  output register contents
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  data_out valid this cycle
- edge_pending  out  1  OR of all sticky edge flags

Behaviour:
- Address map, with OB=0, IB=N_OUT, SB=IB+N_IN, EB=SB+N_SW, ST=EB+N_SW:
  - [OB, IB): out_reg R/W.
  - [IB, SB): synchronised gpio_in, RO.
  - [SB, EB): debounced switch state sw_db, RO.
  - [EB, ST): edge flags, read / W1C.
  - ST: status, RO; bit0 = edge_pending.
  - > ST: reads 0, writes ignored.
  - Elaboration error if ST >= 2**ADDR_W.
- Reset: on any clk edge with rst=1, clear all of the following. rst overrides we/re.
  - out_reg, gpio_out, sync flops, sw_db, debounce counters, edge flags, data_out, rd_valid all 0.
  - edge_pending=0.
- Write, when we=1 at a clk edge:
  - Out region: out_reg[a-OB] <= data_in[0].
  - Edge region: if data_in[0]=1, clear flag[a-EB]; data_in[0]=0 has no effect.
  - RO and unmapped addresses: no state change.
- Read, when re=1 at a clk edge:
  - Next cycle: data_out = {zeros, selected bit}, rd_valid=1.
  - re=0: rd_valid=0 next cycle; data_out holds its last value.
  - Latency is exactly 1 cycle. Back-to-back reads are allowed every cycle.
- Read and write to the same address in the same cycle: read returns the pre-write value.
- gpio_out = out_reg, registered; it changes on the edge that performs the write.
- Synchroniser:
  - Each gpio_in and switches bit passes through a SYNC_STAGES flop chain.
  - The sync output reflects a raw value after SYNC_STAGES edges.
- Debounce, per switch i:
  - If sync[i]==sw_db[i], cnt[i] <= 0.
  - Else, if cnt[i]==DEBOUNCE-1, sw_db[i] toggles and cnt[i] <= 0.
  - Else, cnt[i] increments.
  - A stable change is accepted on the (SYNC_STAGES+DEBOUNCE)th edge after the raw input settles.
  - Pulses shorter than DEBOUNCE synchronised cycles are ignored.
  - Counter width is clog2(DEBOUNCE), minimum 1; the counter never wraps.
- Edge flags:
  - flag[i] sets on the edge where sw_db[i] goes 0->1.
  - Falling edges do not set flags.
  - Set and W1C on the same flag in the same cycle: set wins, flag stays 1.
- edge_pending: combinational OR of the registered flags.
- Reset mid-debounce: counters clear, and the change must be re-qualified from zero.
- A switch held high through reset sets its flag once after re-qualification.

Test Plan:
- Reset and map (SYNC_STAGES=2, DEBOUNCE=4):
  - Write 1 to addr 5, then read addr 5 -> gpio_out[5]=1; rd_valid=1 one cycle after re; data_out=24'h000001.
- Unmapped address:
  - Read addr ST+1 -> data_out=0, rd_valid=1.
  - Write there -> no register changes.
- Debounce:
  - Raise switches[0] and hold -> sw_db[0]=1 on the 6th edge, flag[0]=1, edge_pending=1.
  - A 3-cycle pulse on switches[1] -> sw_db[1] stays 0, no flag.
- W1C collision:
  - Write 1 to EB+2 on the same edge flag[2] sets -> flag stays 1.
  - A later write of 1 clears it; edge_pending falls to 0.
- RAW same cycle:
  - With out_reg[3]=0, we=re=1 at addr 3 with data_in=1 -> data_out=0 next cycle.
  - A following read returns 1.
- Reset mid-operation:
  - Assert rst with cnt[0]=2 and out_reg=all 1s -> all outputs 0 next edge.
  - A held switch re-qualifies and sets its flag 6 edges after rst is released.

Source files
------------

// File: rtl/io_mem_ctrl.sv
// Memory-mapped bit-addressable I/O: GPIO outputs, synchronised GPIO inputs,
// debounced switches with sticky W1C rising-edge flags and a registered read port.
module io_mem_ctrl #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 8,
    parameter int N_OUT       = 36,
    parameter int N_IN        = 36,
    parameter int N_SW        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [N_SW-1:0]   switches,
    input  logic [N_IN-1:0]   gpio_in,
    output logic [N_OUT-1:0]  gpio_out,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              edge_pending
);

    localparam int OB = 0;
    localparam int IB = OB + N_OUT;
    localparam int SB = IB + N_IN;
    localparam int EB = SB + N_SW;
    localparam int ST = EB + N_SW;

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    generate
        if (longint'(ST) >= (longint'(1) << ADDR_W)) begin : g_addr_check
            $error("io_mem_ctrl: address map does not fit in ADDR_W bits");
        end
        if (SYNC_STAGES < 2) begin : g_sync_check
            $error("io_mem_ctrl: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE < 1) begin : g_deb_check
            $error("io_mem_ctrl: DEBOUNCE must be at least 1");
        end
    endgenerate

    logic [N_IN-1:0]  gin_sync [SYNC_STAGES];
    logic [N_SW-1:0]  sw_sync  [SYNC_STAGES];
    logic [N_IN-1:0]  gin_s;
    logic [N_SW-1:0]  sw_s;

    logic [N_OUT-1:0] out_reg;
    logic [N_SW-1:0]  sw_db;
    logic [N_SW-1:0]  flags;
    logic [N_SW-1:0]  sw_tog;
    logic [N_SW-1:0]  sw_rise;
    logic [CNT_W-1:0] cnt [N_SW];
    logic             rd_bit;

    // Only data_in[0] carries write data; the rest of the bus is ignored.
    logic unused_data;
    assign unused_data = &{1'b0, data_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                gin_sync[s] <= '0;
                sw_sync[s]  <= '0;
            end
        end else begin
            gin_sync[0] <= gpio_in;
            sw_sync[0]  <= switches;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                gin_sync[s] <= gin_sync[s-1];
                sw_sync[s]  <= sw_sync[s-1];
            end
        end
    end

    assign gin_s = gin_sync[SYNC_STAGES-1];
    assign sw_s  = sw_sync[SYNC_STAGES-1];

    always_comb begin
        sw_tog  = '0;
        sw_rise = '0;
        for (int i = 0; i < N_SW; i++) begin
            sw_tog[i]  = (sw_s[i] != sw_db[i]) && (cnt[i] == CNT_MAX);
            sw_rise[i] = sw_tog[i] & ~sw_db[i];
        end
    end

    // The counter only runs while the synchronised input disagrees with the
    // accepted state, so any glitch back to the old level restarts qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_db <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (sw_s[i] == sw_db[i]) begin
                    cnt[i] <= '0;
                end else if (sw_tog[i]) begin
                    sw_db[i] <= ~sw_db[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
            flags   <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (we && address == ADDR_W'(OB + i)) begin
                    out_reg[i] <= data_in[0];
                end
            end
            // A new rising edge beats a simultaneous clear so no event is lost.
            for (int i = 0; i < N_SW; i++) begin
                if (sw_rise[i]) begin
                    flags[i] <= 1'b1;
                end else if (we && data_in[0] && address == ADDR_W'(EB + i)) begin
                    flags[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_bit = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (address == ADDR_W'(OB + i)) rd_bit = out_reg[i];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (address == ADDR_W'(IB + i)) rd_bit = gin_s[i];
        end
        for (int i = 0; i < N_SW; i++) begin
            if (address == ADDR_W'(SB + i)) rd_bit = sw_db[i];
            if (address == ADDR_W'(EB + i)) rd_bit = flags[i];
        end
        if (address == ADDR_W'(ST)) rd_bit = edge_pending;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                data_out <= DATA_W'(rd_bit);
            end
        end
    end

    assign gpio_out     = out_reg;
    assign edge_pending = |flags;

endmodule

// File: tb/tb_io_mem_ctrl.sv
// Directed bench for io_mem_ctrl with SYNC_STAGES=2, DEBOUNCE=4.
module tb_io_mem_ctrl;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 8;
    localparam int N_OUT  = 36;
    localparam int N_IN   = 36;
    localparam int N_SW   = 4;
    localparam int IB = 36;
    localparam int SB = 72;
    localparam int EB = 76;
    localparam int ST = 80;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0;
    logic              re = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [N_SW-1:0]   switches = '0;
    logic [N_IN-1:0]   gpio_in = '0;
    logic [N_OUT-1:0]  gpio_out;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              edge_pending;

    int n_cmp = 0;
    int n_err = 0;

    io_mem_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_OUT(N_OUT), .N_IN(N_IN),
        .N_SW(N_SW), .SYNC_STAGES(2), .DEBOUNCE(4)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .address(address),
        .data_in(data_in), .switches(switches), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .data_out(data_out), .rd_valid(rd_valid),
        .edge_pending(edge_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic b);
        we = 1'b1;
        address = ADDR_W'(a);
        data_in = DATA_W'(b);
        tick();
        we = 1'b0;
        data_in = '0;
    endtask

    task automatic rd(input int a, output logic [DATA_W-1:0] d, output logic v);
        re = 1'b1;
        address = ADDR_W'(a);
        tick();
        d = data_out;
        v = rd_valid;
        re = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (gpio_out !== '0) begin n_err++; $display("FAIL reset_gpio_out: got %h expected 0", gpio_out); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL reset_edge_pending: got %b expected 0", edge_pending); end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] d;
        logic v;
        wr(5, 1'b1);
        n_cmp++; if (gpio_out !== 36'h0_0000_0020) begin n_err++; $display("FAIL wr5_gpio_out: got %h expected 000000020", gpio_out); end
        rd(5, d, v);
        n_cmp++; if (d !== 24'h000001) begin n_err++; $display("FAIL rd5_data: got %h expected 000001", d); end
        n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL rd5_valid: got %b expected 1", v); end
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (data_out !== 24'h000001) begin n_err++; $display("FAIL idle_hold: got %h expected 000001", data_out); end
    endtask

    task automatic test_raw();
        logic [DATA_W-1:0] d;
        logic v;
        we = 1'b1;
        re = 1'b1;
        address = ADDR_W'(3);
        data_in = DATA_W'(1);
        tick();
        we = 1'b0;
        re = 1'b0;
        data_in = '0;
        n_cmp++; if (data_out !== 24'h000000) begin n_err++; $display("FAIL raw_old_value: got %h expected 000000", data_out); end
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL raw_valid: got %b expected 1", rd_valid); end
        n_cmp++; if (gpio_out !== 36'h0_0000_0028) begin n_err++; $display("FAIL raw_gpio_out: got %h expected 000000028", gpio_out); end
        rd(3, d, v);
        n_cmp++; if (d !== 24'h000001) begin n_err++; $display("FAIL raw_new_value: got %h expected 000001", d); end
    endtask

    task automatic test_gpio_in();
        logic [DATA_W-1:0] d;
        logic v;
        gpio_in[9] = 1'b1;
        rd(IB + 9, d, v);
        n_cmp++; if (d !== 24'h0) begin n_err++; $display("FAIL gin_edge1: got %h expected 000000", d); end
        rd(IB + 9, d, v);
        n_cmp++; if (d !== 24'h0) begin n_err++; $display("FAIL gin_edge2: got %h expected 000000", d); end
        rd(IB + 9, d, v);
        n_cmp++; if (d !== 24'h1) begin n_err++; $display("FAIL gin_edge3: got %h expected 000001", d); end
        rd(IB + 8, d, v);
        n_cmp++; if (d !== 24'h0) begin n_err++; $display("FAIL gin_other_bit: got %h expected 000000", d); end
    endtask

    task automatic test_unmapped();
        logic [DATA_W-1:0] d;
        logic v;
        rd(5, d, v);
        rd(ST + 1, d, v);
        n_cmp++; if (d !== 24'h0) begin n_err++; $display("FAIL unmapped_data: got %h expected 000000", d); end
        n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL unmapped_valid: got %b expected 1", v); end
        wr(ST + 1, 1'b1);
        wr(IB + 0, 1'b1);
        wr(ST, 1'b1);
        n_cmp++; if (gpio_out !== 36'h0_0000_0028) begin n_err++; $display("FAIL unmapped_wr_gpio: got %h expected 000000028", gpio_out); end
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL unmapped_wr_pending: got %b expected 0", edge_pending); end
    endtask

    task automatic test_debounce();
        logic [DATA_W-1:0] d;
        logic v;
        switches[0] = 1'b1;
        repeat (5) tick();
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL deb_edge5_pending: got %b expected 0", edge_pending); end
        tick();
        n_cmp++; if (edge_pending !== 1'b1) begin n_err++; $display("FAIL deb_edge6_pending: got %b expected 1", edge_pending); end
        rd(SB + 0, d, v);
        n_cmp++; if (d !== 24'h1) begin n_err++; $display("FAIL deb_sw0_state: got %h expected 000001", d); end
        rd(EB + 0, d, v);
        n_cmp++; if (d !== 24'h1) begin n_err++; $display("FAIL deb_flag0: got %h expected 000001", d); end
        rd(ST, d, v);
        n_cmp++; if (d !== 24'h1) begin n_err++; $display("FAIL deb_status: got %h expected 000001", d); end
        switches[1] = 1'b1;
        repeat (3) tick();
        switches[1] = 1'b0;
        repeat (10) tick();
        rd(SB + 1, d, v);
        n_cmp++; if (d !== 24'h0) begin n_err++; $display("FAIL pulse_sw1_state: got %h expected 000000", d); end
        rd(EB + 1, d, v);
        n_cmp++; if (d !== 24'h0) begin n_err++; $display("FAIL pulse_flag1: got %h expected 000000", d); end
    endtask

    task automatic test_w1c();
        wr(EB + 0, 1'b0);
        n_cmp++; if (edge_pending !== 1'b1) begin n_err++; $display("FAIL w0_no_clear: got %b expected 1", edge_pending); end
        wr(EB + 0, 1'b1);
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL w1c_flag0: got %b expected 0", edge_pending); end
        switches[2] = 1'b1;
        repeat (5) tick();
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL w1c_pre_set: got %b expected 0", edge_pending); end
        wr(EB + 2, 1'b1);
        n_cmp++; if (edge_pending !== 1'b1) begin n_err++; $display("FAIL w1c_collision_set_wins: got %b expected 1", edge_pending); end
        wr(EB + 2, 1'b1);
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL w1c_flag2_clear: got %b expected 0", edge_pending); end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        logic v;
        switches = '0;
        repeat (10) tick();
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL fall_no_flag: got %b expected 0", edge_pending); end
        for (int i = 0; i < N_OUT; i++) wr(i, 1'b1);
        n_cmp++; if (gpio_out !== {N_OUT{1'b1}}) begin n_err++; $display("FAIL all_ones_gpio: got %h expected fffffffff", gpio_out); end
        rd(0, d, v);
        switches[0] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (gpio_out !== '0) begin n_err++; $display("FAIL midrst_gpio_out: got %h expected 0", gpio_out); end
        n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL midrst_data_out: got %h expected 0", data_out); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rd_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL midrst_pending: got %b expected 0", edge_pending); end
        repeat (5) tick();
        n_cmp++; if (edge_pending !== 1'b0) begin n_err++; $display("FAIL requal_edge5: got %b expected 0", edge_pending); end
        tick();
        n_cmp++; if (edge_pending !== 1'b1) begin n_err++; $display("FAIL requal_edge6: got %b expected 1", edge_pending); end
        rd(EB + 0, d, v);
        n_cmp++; if (d !== 24'h1) begin n_err++; $display("FAIL requal_flag0: got %h expected 000001", d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_raw();
        test_gpio_in();
        test_unmapped();
        test_debounce();
        test_w1c();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
